// File: rtl/dram_port_arbiter.sv
// Three-way round-robin arbiter in front of a single DRAM command port.
// Optional ARB_WRITE_PRIORITY_EN: output-write requester (req[2]) always wins arbitration.
module dram_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               req,
  input  logic [3*ADDR_W-1:0]      req_addr,
  input  logic [2:0]               req_we,
  input  logic [11:0]              req_len,
  output logic [2:0]               gnt,
  output logic [2:0]               gnt_done,
  output logic                     dram_cmd_valid,
  input  logic                     dram_cmd_ready,
  output logic                     dram_cmd_we,
  output logic [ADDR_W-1:0]        dram_cmd_addr,
  output logic [3:0]               dram_cmd_len,
  input  logic                     dram_beat_done,
  output logic                     busy,
  output logic [3*STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StBurst} state_e;

  state_e                 state_q;
  logic [1:0]             last_grant_q;
  logic [1:0]             cur_q;
  logic [3:0]             beat_cnt_q;
  logic [STALL_CNT_W-1:0] stall_q [3];

  logic [1:0] rr_win;
  logic [1:0] winner;
  int         idx;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    rr_win = 2'd0;
    idx    = 0;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % 3;
      if (req[idx[1:0]]) rr_win = idx[1:0];
    end
  end

`ifdef ARB_WRITE_PRIORITY_EN
  assign winner = req[2] ? 2'd2 : rr_win;
`else
  assign winner = rr_win;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      last_grant_q   <= 2'd2;
      cur_q          <= 2'd0;
      beat_cnt_q     <= 4'd0;
      gnt            <= 3'b000;
      gnt_done       <= 3'b000;
      dram_cmd_valid <= 1'b0;
      dram_cmd_we    <= 1'b0;
      dram_cmd_addr  <= '0;
      dram_cmd_len   <= 4'd0;
      busy           <= 1'b0;
    end else begin
      gnt_done <= 3'b000;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            cur_q          <= winner;
            gnt            <= 3'b001 << winner;
            dram_cmd_valid <= 1'b1;
            dram_cmd_we    <= req_we[winner];
            dram_cmd_addr  <= req_addr[winner*ADDR_W +: ADDR_W];
            dram_cmd_len   <= req_len[winner*4 +: 4];
            busy           <= 1'b1;
            state_q        <= StIssue;
          end
        end
        StIssue: begin
          if (dram_cmd_ready) begin
            dram_cmd_valid <= 1'b0;
            beat_cnt_q     <= 4'd0;
            state_q        <= StBurst;
          end
        end
        StBurst: begin
          if (dram_beat_done) begin
            if (beat_cnt_q == dram_cmd_len) begin
              gnt_done <= gnt;
              gnt      <= 3'b000;
              busy     <= 1'b0;
              state_q  <= StIdle;
`ifdef ARB_WRITE_PRIORITY_EN
              // Priority grants to the writer leave the 0/1 rotation untouched.
              if (cur_q != 2'd2) last_grant_q <= cur_q;
`else
              last_grant_q <= cur_q;
`endif
            end else begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (req[i] && !gnt[i] && (stall_q[i] != '1)) stall_q[i] <= stall_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_stall
    assign stall_cnt[g*STALL_CNT_W +: STALL_CNT_W] = stall_q[g];
  end

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the DRAM address width.
REQ-002 The block SHALL have parameter STALL_CNT_W, default 16, meaning the width of each stall counter.
REQ-003 The block SHALL have the following ports: clk  in  1  the single clock.
REQ-004 rst_n  in  1  reset; asynchronous and active-low.
REQ-005 req  in  3  per-requester request (bit0 weight load, bit1 activation read, bit2 output write).
REQ-006 req_addr  in  3*ADDR_W  per-requester start address; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-007 req_we  in  3  per-requester write flag.
REQ-008 req_len  in  3*4  per-requester burst length; beats = req_len+1 (1..16).
REQ-009 gnt  out  3  one-hot grant, held from latch until burst end.
REQ-010 gnt_done  out  3  one-cycle pulse on the completing requester's bit.
REQ-011 dram_cmd_valid  out  1  command valid.
REQ-012 dram_cmd_ready  in  1  command accepted when high with valid.
REQ-013 dram_cmd_we, dram_cmd_addr, dram_cmd_len  out  1/ADDR_W/4  latched command fields.
REQ-014 dram_beat_done  in  1  one data beat completed this cycle.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 stall_cnt  out  3*STALL_CNT_W  per-requester count of cycles with req high and gnt low; saturating.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and BURST.
REQ-018 In IDLE with any req bit high, the block SHALL select a winner, latch its addr/we/len, assert gnt[winner] and go to ISSUE on the next edge.
REQ-019 Round-robin selection SHALL search from index (last_grant+1) mod 3 upward with wrap; last_grant resets to 2, so requester 0 wins first.
REQ-020 In ISSUE, dram_cmd_valid SHALL be 1 with the latched fields held stable; on valid&&ready the block SHALL go to BURST with the beat counter at 0.
REQ-021 In BURST, each dram_beat_done SHALL increment the beat counter; the beat at which counter == latched len SHALL pulse gnt_done[winner], clear gnt, update last_grant and return to IDLE in the same edge.
REQ-022 dram_beat_done outside BURST SHALL be ignored.
REQ-023 Deassertion of req during ISSUE or BURST SHALL NOT abort the burst; the burst completes and gnt_done still pulses.
REQ-024 Changes to req_addr/we/len after latch SHALL NOT affect the running command.
REQ-025 The arbiter SHALL NOT grant in the cycle gnt_done pulses, so the minimum idle gap is one cycle in IDLE.
REQ-026 A requester with req high and gnt low SHALL increment its stall counter each cycle; the counter saturates at all-ones and never wraps.
REQ-027 At most one gnt bit SHALL be high in any cycle.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, gnt=0, gnt_done=0, dram_cmd_valid=0, dram_cmd_we=0, dram_cmd_addr=0, dram_cmd_len=0, busy=0, stall_cnt=0, beat counter=0, last_grant=2.
REQ-029 Reset mid-burst SHALL abandon the burst with no gnt_done pulse; the first grant after reset follows REQ-019.

Configuration
REQ-030 When macro ARB_WRITE_PRIORITY_EN is defined, req[2] SHALL win over any other request in IDLE and SHALL NOT update last_grant; requesters 0 and 1 stay round-robin between themselves.
REQ-031 When ARB_WRITE_PRIORITY_EN is undefined, all three requesters SHALL use pure round-robin per REQ-019.

Verification
REQ-032 Reset, then req=3'b111 held, all len=0, ready=1, one beat per burst -> grant order 0,1,2,0; each gnt_done one cycle.
REQ-033 req[1] with addr=0x1000, we=0, len=3; ready held low 5 cycles -> valid held with addr 0x1000 and len 3 for 5 cycles; gnt_done[1] after the 4th beat.
REQ-034 req[0] dropped mid-burst with len=15 -> all 16 beats complete; gnt_done[0] pulses; stall_cnt unchanged for requester 0.
REQ-035 Stimulus: req[2] held behind a 16-beat burst from requester 0. Required response: stall_cnt[2] equals the exact number of waiting cycles. Second stimulus: force stall_cnt to 0xFFFE and wait 3 cycles. Required response: stall_cnt reads 0xFFFF.
REQ-036 rst_n low during BURST beat 2 -> all outputs 0 immediately; no gnt_done pulse.
REQ-037 With ARB_WRITE_PRIORITY_EN defined and req=3'b111 -> requester 2 wins every arbitration while req[2] stays high.
